pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of PC and all address ports.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value after reset.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4 (power of two, 2..16): return-address-stack entries.
REQ-004 The block SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port stall, input, 1: hold all state this cycle.
REQ-007 The block SHALL have port next_pc_src, input, 2: 0 = PC+4, 1 = alu_res (branch/jal), 2 = trap_vec, 3 = RAS pop (return).
REQ-008 The block SHALL have port alu_res, input, XLEN: computed branch/jump target.
REQ-009 The block SHALL have port trap_vec, input, XLEN: trap handler address.
REQ-010 The block SHALL have port ras_push, input, 1: call; push PC+4.
REQ-011 The block SHALL have port pc, output, XLEN: current PC (registered).
REQ-012 The block SHALL have port pc_plus4, output, XLEN: pc + 4, combinational.
REQ-013 The block SHALL have port misaligned, output, 1: one-cycle pulse, misaligned target rejected.
REQ-014 The block SHALL have port ras_underflow, output, 1: one-cycle pulse, pop on empty stack.
REQ-015 The block SHALL have port ras_count, output, $clog2(RAS_DEPTH)+1: valid RAS entries.
REQ-016 The block SHALL have port redirect_cnt, output, 16: count of non-sequential PC updates.

Function
REQ-017 When stall=0, the block SHALL load pc on each rising clk edge with the target selected by next_pc_src.
REQ-018 pc_plus4 SHALL equal pc + 4 modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
REQ-019 For src 1 or 3 with target[1:0] != 0, pc SHALL load trap_vec and misaligned SHALL pulse high for the next cycle.
REQ-020 src 3 with ras_count = 0 SHALL load pc_plus4, leave the stack unchanged, and pulse ras_underflow.
REQ-021 src 3 with a non-empty stack SHALL load the top entry and decrement ras_count.
REQ-022 ras_push (stall=0) SHALL write the current pc_plus4 on top and increment ras_count.
REQ-023 A push when full SHALL overwrite the oldest entry as a circular buffer, with ras_count held at RAS_DEPTH.
REQ-024 A push and a valid pop in the same cycle SHALL pop first and then push, leaving ras_count unchanged and the top equal to the new pc_plus4.
REQ-025 redirect_cnt SHALL increment on every non-stalled update where the loaded value != pc_plus4, saturating at 16'hFFFF.
REQ-026 When stall=1, pc, the RAS, ras_count and redirect_cnt SHALL hold, and misaligned and ras_underflow SHALL be 0 next cycle.
REQ-027 misaligned and ras_underflow SHALL never be high for more than one cycle per triggering event.

Reset
REQ-028 When rst is asserted, the block SHALL immediately set pc = RESET_VECTOR, ras_count = 0, redirect_cnt = 0, misaligned = 0 and ras_underflow = 0, without waiting for clk.
REQ-029 Reset asserted mid-operation SHALL discard all RAS contents; the first update after deassertion SHALL use pc = RESET_VECTOR.
REQ-030 RAS entry storage SHALL not require reset; entries at or above ras_count are never observable.

Structure
REQ-031 Package pc_pkg SHALL hold the next_pc_src encoding enum (PC_SEQ, PC_ALU, PC_TRAP, PC_RAS) and the constant PC_STEP = 4.
REQ-032 The stack SHALL be a sub-module ras_stack (push, pop, top, count, full, empty), parametrised by XLEN and RAS_DEPTH.
REQ-033 pc_next_unit SHALL contain the PC register, target selection, alignment check, pulse registers and redirect counter.

Verification
REQ-034 Test 1: reset with RESET_VECTOR=32'h100, then 3 cycles of src=0 -> pc sequence 100, 104, 108, 10C; redirect_cnt = 0.
REQ-035 Test 2: pc=32'h200, src=1, alu_res=32'h203 -> next pc = trap_vec (32'h80); misaligned high exactly one cycle; redirect_cnt = 1.
REQ-036 Test 3 (RAS_DEPTH=4): push at pc 0x10, 0x20, 0x30, 0x40, 0x50, then 5 pops -> targets 0x54, 0x44, 0x34, 0x24; ras_count 4→0; 5th pop loads pc_plus4 with ras_underflow pulse.
REQ-037 Test 4: stall=1 for 3 cycles while src=1 and alu_res=32'h400 -> pc, ras_count and redirect_cnt are unchanged; after release pc = 32'h400.
REQ-038 Test 5: simultaneous push and pop at pc=32'h300 with top=32'h104 -> pc = 32'h104, new top = 32'h304, ras_count unchanged.
REQ-039 Test 6: rst asserted mid-clock with ras_count=3 -> pc = RESET_VECTOR and ras_count = 0 before the next edge; a following pop raises ras_underflow.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings and constants for the next-PC unit
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_ALU  = 2'd1,
        PC_TRAP = 2'd2,
        PC_RAS  = 2'd3
    } pc_src_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack, oldest entry overwritten when full
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned AW       = $clog2(RAS_DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0]   wp_q;
    logic [CW-1:0]   count_q;
    logic            pop_eff;

    assign full    = (count_q == CW'(RAS_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top     = mem_q[wp_q - PTR_ONE];
    assign pop_eff = pop && !empty;

    // Write pointer and occupancy; a pop followed by a push leaves both unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    wp_q    <= wp_q + PTR_ONE;
                    count_q <= full ? count_q : count_q + CW'(1);
                end
                2'b01: begin
                    wp_q    <= wp_q - PTR_ONE;
                    count_q <= count_q - CW'(1);
                end
                default: begin
                    wp_q    <= wp_q;
                    count_q <= count_q;
                end
            endcase
        end
    end

    // Entry storage needs no reset: slots beyond count are never read as valid
    always_ff @(posedge clk) begin
        if (push) begin
            if (pop_eff) begin
                mem_q[wp_q - PTR_ONE] <= push_data;
            end else begin
                mem_q[wp_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC register with target selection, alignment check and return-address stack
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [1:0]                   next_pc_src,
    input  logic [XLEN-1:0]              alu_res,
    input  logic [XLEN-1:0]              trap_vec,
    input  logic                         ras_push,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus4,
    output logic                         misaligned,
    output logic                         ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [15:0]                  redirect_cnt
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic            unf_q, unf_d;
    logic [15:0]     redir_q, redir_d;

    pc_src_e         src;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full_unused;
    logic            pop_req;
    logic            underflow_ev;
    logic            mis_ev;

    assign src      = pc_src_e'(next_pc_src);
    assign pc_plus4 = pc_q + XLEN'(PC_STEP);

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push && !stall),
        .pop       (pop_req && !stall),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full_unused),
        .empty     (ras_empty)
    );

    // Select the candidate target, reject misaligned jumps/returns to the trap vector
    always_comb begin
        target       = pc_plus4;
        pop_req      = 1'b0;
        underflow_ev = 1'b0;
        case (src)
            PC_SEQ:  target = pc_plus4;
            PC_ALU:  target = alu_res;
            PC_TRAP: target = trap_vec;
            PC_RAS: begin
                if (ras_empty) begin
                    target       = pc_plus4;
                    underflow_ev = 1'b1;
                end else begin
                    target  = ras_top;
                    pop_req = 1'b1;
                end
            end
            default: target = pc_plus4;
        endcase
        mis_ev = ((src == PC_ALU) || pop_req) && (target[1:0] != 2'b00);

        pc_d    = pc_q;
        mis_d   = 1'b0;
        unf_d   = 1'b0;
        redir_d = redir_q;
        if (!stall) begin
            pc_d  = mis_ev ? trap_vec : target;
            mis_d = mis_ev;
            unf_d = underflow_ev;
            if ((pc_d != pc_plus4) && (redir_q != 16'hFFFF)) begin
                redir_d = redir_q + 16'd1;
            end
        end
    end

    // PC, event pulses and redirect counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
            unf_q   <= 1'b0;
            redir_q <= '0;
        end else begin
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            unf_q   <= unf_d;
            redir_q <= redir_d;
        end
    end

    assign pc            = pc_q;
    assign misaligned    = mis_q;
    assign ras_underflow = unf_q;
    assign redirect_cnt  = redir_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  next_pc_src;
    logic [31:0] alu_res;
    logic [31:0] trap_vec;
    logic        ras_push;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        ras_underflow;
    logic [2:0]  ras_count;
    logic [15:0] redirect_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pc_next_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .next_pc_src   (next_pc_src),
        .alu_res       (alu_res),
        .trap_vec      (trap_vec),
        .ras_push      (ras_push),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned),
        .ras_underflow (ras_underflow),
        .ras_count     (ras_count),
        .redirect_cnt  (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        n_total++; if (pc !== 32'h100) $display("FAIL reset_pc got %h exp %h", pc, 32'h100); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h104) $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h104); else n_pass++;
        n_total++; if (ras_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", ras_count); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd0) $display("FAIL reset_redir got %0d exp 0", redirect_cnt); else n_pass++;
        n_total++; if (misaligned !== 1'b0 || ras_underflow !== 1'b0)
            $display("FAIL reset_pulses got %b%b exp 00", misaligned, ras_underflow); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10C;
        next_pc_src = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (pc !== exp_pc[i]) $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pc[i]); else n_pass++;
        end
        n_total++; if (redirect_cnt !== 16'd0) $display("FAIL seq_redir got %0d exp 0", redirect_cnt); else n_pass++;
    endtask

    task automatic test_misaligned;
        next_pc_src = 2'd1; alu_res = 32'h200;
        step();
        n_total++; if (pc !== 32'h200) $display("FAIL mis_setup_pc got %h exp %h", pc, 32'h200); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd1) $display("FAIL mis_setup_redir got %0d exp 1", redirect_cnt); else n_pass++;
        alu_res = 32'h203;
        step();
        n_total++; if (pc !== 32'h80) $display("FAIL mis_pc got %h exp %h", pc, 32'h80); else n_pass++;
        n_total++; if (misaligned !== 1'b1) $display("FAIL mis_pulse got %b exp 1", misaligned); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd2) $display("FAIL mis_redir got %0d exp 2", redirect_cnt); else n_pass++;
        next_pc_src = 2'd0;
        step();
        n_total++; if (misaligned !== 1'b0) $display("FAIL mis_pulse_end got %b exp 0", misaligned); else n_pass++;
        n_total++; if (pc !== 32'h84) $display("FAIL mis_after_pc got %h exp %h", pc, 32'h84); else n_pass++;
    endtask

    task automatic test_trap_and_wrap;
        trap_vec = 32'h80; next_pc_src = 2'd2;
        step();
        n_total++; if (pc !== 32'h80) $display("FAIL trap_pc got %h exp %h", pc, 32'h80); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd3) $display("FAIL trap_redir got %0d exp 3", redirect_cnt); else n_pass++;
        next_pc_src = 2'd1; alu_res = 32'hFFFF_FFFC;
        step();
        n_total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h exp %h", pc_plus4, 32'h0); else n_pass++;
        next_pc_src = 2'd0;
        step();
        n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd4) $display("FAIL wrap_redir got %0d exp 4", redirect_cnt); else n_pass++;
    endtask

    task automatic test_ras;
        logic [31:0] exp_top [4];
        logic [2:0]  exp_cnt;
        exp_top[0] = 32'h54; exp_top[1] = 32'h44; exp_top[2] = 32'h34; exp_top[3] = 32'h24;
        do_reset();
        next_pc_src = 2'd1; alu_res = 32'h10; ras_push = 1'b0;
        step();
        n_total++; if (pc !== 32'h10) $display("FAIL ras_setup_pc got %h exp %h", pc, 32'h10); else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            alu_res  = 32'((i + 1) * 16);
            ras_push = 1'b1;
            step();
            exp_cnt = (i > 4) ? 3'd4 : 3'(i);
            n_total++; if (ras_count !== exp_cnt) $display("FAIL ras_push_cnt%0d got %0d exp %0d", i, ras_count, exp_cnt); else n_pass++;
        end
        ras_push = 1'b0; next_pc_src = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_cnt = 3'(3 - k);
            n_total++; if (pc !== exp_top[k]) $display("FAIL ras_pop_pc%0d got %h exp %h", k, pc, exp_top[k]); else n_pass++;
            n_total++; if (ras_count !== exp_cnt) $display("FAIL ras_pop_cnt%0d got %0d exp %0d", k, ras_count, exp_cnt); else n_pass++;
        end
        step();
        n_total++; if (pc !== 32'h28) $display("FAIL ras_unf_pc got %h exp %h", pc, 32'h28); else n_pass++;
        n_total++; if (ras_underflow !== 1'b1) $display("FAIL ras_unf_pulse got %b exp 1", ras_underflow); else n_pass++;
        n_total++; if (ras_count !== 3'd0) $display("FAIL ras_unf_cnt got %0d exp 0", ras_count); else n_pass++;
        next_pc_src = 2'd0;
        step();
        n_total++; if (ras_underflow !== 1'b0) $display("FAIL ras_unf_end got %b exp 0", ras_underflow); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd10) $display("FAIL ras_redir got %0d exp 10", redirect_cnt); else n_pass++;
    endtask

    task automatic test_stall;
        next_pc_src = 2'd0; ras_push = 1'b1;
        step();
        n_total++; if (pc !== 32'h30) $display("FAIL stall_setup_pc got %h exp %h", pc, 32'h30); else n_pass++;
        stall = 1'b1; next_pc_src = 2'd1; alu_res = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (pc !== 32'h30) $display("FAIL stall_pc%0d got %h exp %h", i, pc, 32'h30); else n_pass++;
            n_total++; if (ras_count !== 3'd1) $display("FAIL stall_cnt%0d got %0d exp 1", i, ras_count); else n_pass++;
            n_total++; if (redirect_cnt !== 16'd10) $display("FAIL stall_redir%0d got %0d exp 10", i, redirect_cnt); else n_pass++;
        end
        stall = 1'b0; ras_push = 1'b0;
        step();
        n_total++; if (pc !== 32'h400) $display("FAIL stall_release_pc got %h exp %h", pc, 32'h400); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd11) $display("FAIL stall_release_redir got %0d exp 11", redirect_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        next_pc_src = 2'd1; alu_res = 32'h100; ras_push = 1'b0;
        step();
        alu_res = 32'h300; ras_push = 1'b1;
        step();
        n_total++; if (pc !== 32'h300) $display("FAIL b2b_setup_pc got %h exp %h", pc, 32'h300); else n_pass++;
        n_total++; if (ras_count !== 3'd1) $display("FAIL b2b_setup_cnt got %0d exp 1", ras_count); else n_pass++;
        next_pc_src = 2'd3; ras_push = 1'b1;
        step();
        n_total++; if (pc !== 32'h104) $display("FAIL b2b_pc got %h exp %h", pc, 32'h104); else n_pass++;
        n_total++; if (ras_count !== 3'd1) $display("FAIL b2b_cnt got %0d exp 1", ras_count); else n_pass++;
        ras_push = 1'b0;
        step();
        n_total++; if (pc !== 32'h304) $display("FAIL b2b_newtop got %h exp %h", pc, 32'h304); else n_pass++;
        n_total++; if (ras_count !== 3'd0) $display("FAIL b2b_drain_cnt got %0d exp 0", ras_count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        next_pc_src = 2'd0; ras_push = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_total++; if (ras_count !== 3'd3) $display("FAIL rmid_setup_cnt got %0d exp 3", ras_count); else n_pass++;
        ras_push = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (pc !== 32'h100) $display("FAIL rmid_pc got %h exp %h", pc, 32'h100); else n_pass++;
        n_total++; if (ras_count !== 3'd0) $display("FAIL rmid_cnt got %0d exp 0", ras_count); else n_pass++;
        n_total++; if (redirect_cnt !== 16'd0) $display("FAIL rmid_redir got %0d exp 0", redirect_cnt); else n_pass++;
        #1;
        rst = 1'b0;
        next_pc_src = 2'd3;
        step();
        n_total++; if (ras_underflow !== 1'b1) $display("FAIL rmid_unf got %b exp 1", ras_underflow); else n_pass++;
        n_total++; if (pc !== 32'h104) $display("FAIL rmid_unf_pc got %h exp %h", pc, 32'h104); else n_pass++;
        next_pc_src = 2'd0;
        step();
        n_total++; if (ras_underflow !== 1'b0) $display("FAIL rmid_unf_end got %b exp 0", ras_underflow); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; next_pc_src = 2'd0;
        alu_res = '0; trap_vec = 32'h80; ras_push = 1'b0;
        test_reset();
        test_sequential();
        test_misaligned();
        test_trap_and_wrap();
        test_ras();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
